// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand/op input channel, result output channel, occupancy.
// With LOGIC_GATE_PIPE_STATS_EN defined the bundle also carries the ops_done counter.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic             zero;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0]      ops_done;
`endif

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, c, zero, out_valid, count
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , input ops_done
`endif
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, c, zero, out_valid, count
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , output ops_done
`endif
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Bitwise AND/OR/XOR/NAND unit feeding a DEPTH-entry result FIFO with a registered head (C/ZERO).
// Define LOGIC_GATE_PIPE_STATS_EN to add the saturating ops_done handshake counter.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  logic_gate_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             run_q;
  logic [WIDTH-1:0] c_q;
  logic             zero_q;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head_next;
  logic             push;
  logic             pop;

  // run_q keeps in_ready low for the cycle following a reset edge
  assign bus.in_ready  = run_q && (count_q != CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.c         = c_q;
  assign bus.zero      = zero_q;
  assign bus.count     = count_q;

  assign push       = bus.in_valid && bus.in_ready;
  assign pop        = bus.out_valid && bus.out_ready;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    result = '0;
    case (bus.op)
      2'b00:   result = bus.a & bus.b;
      2'b01:   result = bus.a | bus.b;
      2'b10:   result = bus.a ^ bus.b;
      default: result = ~(bus.a & bus.b);
    endcase
  end

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + CW'(1);
    else if (pop && !push)
      count_next = count_q - CW'(1);
  end

  // Head register: takes the incoming result when it becomes the head, else the next stored entry
  always_comb begin
    head_next = c_q;
    if (push && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
      head_next = result;
    else if (pop && (count_next != '0))
      head_next = mem[rd_ptr_inc];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
      c_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      run_q   <= 1'b1;
      count_q <= count_next;
      c_q     <= head_next;
      zero_q  <= (head_next == '0);
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr_inc;
    end
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk) begin
    if (rst)
      ops_q <= '0;
    else if (pop && (ops_q != 16'hFFFF))
      ops_q <= ops_q + 16'd1;
  end

  assign bus.ops_done = ops_q;
`endif

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4: result buffer entries; power of two, legal range 2..16.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, synchronous, active-high.
REQ-005 A  input  WIDTH: operand A.
REQ-006 B  input  WIDTH: operand B.
REQ-007 OP  input  2: operation select; 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 IN_VALID  input  1: A/B/OP valid this cycle.
REQ-009 IN_READY  output  1: block can accept an operation this cycle.
REQ-010 C  output  WIDTH: result at head of buffer.
REQ-011 ZERO  output  1: result at head of buffer is all zeros.
REQ-012 OUT_VALID  output  1: C/ZERO valid.
REQ-013 OUT_READY  input  1: consumer accepts C this cycle.
REQ-014 COUNT  output  log2(DEPTH)+1: number of results held, 0..DEPTH.

Function
REQ-015 Input handshake occurs on a rising edge where IN_VALID and IN_READY are both high; the result of OP applied bitwise to A and B is written to the buffer tail on that edge.
REQ-016 Output handshake occurs on a rising edge where OUT_VALID and OUT_READY are both high; the head entry is removed on that edge.
REQ-017 Latency is exactly one cycle: a result accepted at edge k drives C and OUT_VALID in the cycle after edge k; there is no combinational path from A/B/OP/IN_VALID to C/OUT_VALID.
REQ-018 IN_READY is high when COUNT < DEPTH, and it depends on registered state only (no combinational dependence on OUT_READY).
REQ-019 OUT_VALID is high when COUNT > 0.
REQ-020 The buffer is FIFO ordered; results leave in the order they were accepted.
REQ-021 Simultaneous input and output handshakes on one edge leave COUNT unchanged and are legal at any 0 < COUNT < DEPTH.
REQ-022 When full (COUNT = DEPTH), IN_VALID is ignored even if an output handshake occurs on the same edge; IN_READY rises the cycle after.
REQ-023 When empty, OUT_READY is ignored; C and ZERO hold their last values, or reset values if nothing has been accepted since reset.
REQ-024 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH without special handling.
REQ-025 The result is not altered when OP, A or B change after acceptance.

Reset
REQ-026 While RST is high at a rising edge: COUNT=0, pointers=0, OUT_VALID=0, IN_READY=0 during the reset cycle, C=0, ZERO=1.
REQ-027 IN_READY is high in the first cycle after RST deasserts.
REQ-028 RST mid-operation discards all buffered results; handshakes on the same edge as RST are dropped.

Configuration
REQ-029 Macro LOGIC_GATE_PIPE_STATS_EN, when defined, adds output OPS_DONE (16 bits): the count of output handshakes since reset, saturating at 16'hFFFF, reset to 0.
REQ-030 When LOGIC_GATE_PIPE_STATS_EN is undefined, port OPS_DONE and its counter are absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=8: A=8'hF0, B=8'h3C, OP=00..11, OUT_READY=1 -> C = 8'h30, 8'hFC, 8'hCC, 8'hCF on consecutive cycles, each one cycle after acceptance.
REQ-032 A=8'h0F, B=8'hF0, OP=00 -> C=8'h00, ZERO=1; OP=01 -> C=8'hFF, ZERO=0.
REQ-033 DEPTH=4, OUT_READY=0, 6 back-to-back inputs -> first 4 accepted, IN_READY=0, COUNT=4; then OUT_READY=1 -> 4 results drain in order, COUNT reaches 0.
REQ-034 COUNT=2, IN_VALID=1 and OUT_READY=1 for 10 cycles -> COUNT stays 2, pointers wrap, output order preserved.
REQ-035 RST asserted with COUNT=3 -> next cycle COUNT=0, OUT_VALID=0, C=0, ZERO=1; IN_READY=1 the cycle after RST drops.
REQ-036 With LOGIC_GATE_PIPE_STATS_EN defined, 70000 output handshakes -> OPS_DONE=16'hFFFF; RST -> OPS_DONE=0.
